subckt_tt_capture: RTL
======================

SUBCKT_TT_CAPTURE -- requirements
Module: subckt_tt_capture

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning the wait cycles after each vector is driven before sampling (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start_i, input, 1 bit: request to begin a 16-vector sweep.
REQ-005 SHALL have port busy_o, output, 1 bit: high while a sweep is in progress.
REQ-006 SHALL have port vec_o, output, 4 bits: drives the 4-input sub-circuit; bit0=n_1, bit1=n_2, bit2=n_3, bit3=n_4.
REQ-007 SHALL have port dut_out_i, input, 1 bit: the sub-circuit's single output (n_8).
REQ-008 SHALL have port tt_o, output, 16 bits: captured truth table; bit k = dut_out_i sampled while vec_o==k.
REQ-009 SHALL have port tt_valid_o, output, 1 bit: tt_o is complete.
REQ-010 SHALL have port tt_ready_i, input, 1 bit: consumer accepts tt_o.
REQ-011 SHALL have port toggle_cnt_o, output, 4 bits: count of output changes between consecutive vectors (present only under the macro in REQ-024).

Function
REQ-012 SHALL implement the FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-013 In IDLE, start_i=1 SHALL go to DRIVE, set vec_o=0, clear the settle counter and clear tt_o and toggle_cnt_o.
REQ-014 DRIVE SHALL hold vec_o for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-015 SAMPLE SHALL last one cycle and write dut_out_i into tt_o[vec_o].
- vec_o<15: increment vec_o, go to DRIVE.
- vec_o==15: go to DONE; vec_o wraps to 0.
REQ-016 SHALL raise tt_valid_o exactly 16*(SETTLE_CYCLES+1) cycles after the start-accepting edge.
REQ-017 DONE SHALL hold tt_valid_o=1 and tt_o stable until tt_ready_i=1, then return to IDLE on that edge.
REQ-018 A start_i seen in DRIVE, SAMPLE or DONE SHALL be ignored; this includes start_i in the same cycle as the tt_valid_o/tt_ready_i handshake.
REQ-019 tt_o SHALL keep its last value in IDLE until the next accepted start.
REQ-020 busy_o SHALL be 1 exactly in DRIVE and SAMPLE.
REQ-021 The toggle counter SHALL increment in SAMPLE for vec_o>0 when dut_out_i differs from tt_o[vec_o-1]; its maximum is 15, so it never saturates.

Reset
REQ-022 rst_n=0 SHALL immediately force the following, including mid-sweep, with no partial result retained:
- state=IDLE
- vec_o=0, tt_o=0, toggle_cnt_o=0
- tt_valid_o=0, busy_o=0
- settle counter=0
REQ-023 After rst_n deasserts, the first start SHALL be accepted no earlier than the first clk rising edge.

Configuration
REQ-024 Macro SUBCKT_TOGGLE_COUNT_EN:
- Defined: toggle_cnt_o and its counter SHALL exist and follow REQ-021.
- Undefined: the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Package subckt_pkg SHALL hold:
- VEC_W=4 and TT_W=16
- the FSM state enum (IDLE, DRIVE, SAMPLE, DONE)
- the default SETTLE_CYCLES constant
REQ-026 The settle counter SHALL be a sub-module, subckt_settle_timer (load, count-down, done pulse); all other logic SHALL be flat.

Verification
REQ-027 Connect the bench model n_8 = (n_1&(n_2^n_4))^(n_2&n_3), SETTLE_CYCLES=2, pulse start_i -> tt_valid_o rises 48 cycles later with tt_o=16'hE248 and toggle_cnt_o=7.
REQ-028 Tie dut_out_i=1 and run a sweep -> tt_o=16'hFFFF and toggle_cnt_o=0; tie dut_out_i=0 -> tt_o=16'h0000.
REQ-029 Hold tt_ready_i=0 for 20 cycles after tt_valid_o rises -> tt_valid_o and tt_o stay constant; raise tt_ready_i -> IDLE on the next edge.
REQ-030 Pulse start_i while vec_o=7 and while in DONE -> no restart, with the same result as REQ-027.
REQ-031 Assert rst_n=0 while vec_o=9 -> all outputs are 0 immediately; a new start then gives 16'hE248 again.
REQ-032 SETTLE_CYCLES=1 with dut_out_i = the registered vec_o[0] -> tt_o=16'hAAAA, toggle_cnt_o=15, latency 32 cycles.

Source files
------------

// File: rtl/subckt_pkg.sv
// subckt_pkg: shared widths, FSM state encoding and default settle time for the truth-table capture
package subckt_pkg;
  localparam int VEC_W = 4;
  localparam int TT_W = 16;
  localparam int SETTLE_DEFAULT = 2;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/subckt_settle_timer.sv
// subckt_settle_timer: loadable count-down timer, done while enabled and expired
module subckt_settle_timer
  import subckt_pkg::*;
#(
  parameter int CYCLES = SETTLE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= 4'(CYCLES - 1);
    else if (en && cnt != '0) cnt <= cnt - 4'd1;
  assign done = en && cnt == '0;
endmodule

// File: rtl/subckt_tt_capture.sv
// subckt_tt_capture: sweeps 16 input vectors and captures the truth table; toggle counter under SUBCKT_TOGGLE_COUNT_EN
module subckt_tt_capture
  import subckt_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic             busy_o,
  output logic [VEC_W-1:0] vec_o,
  input  logic             dut_out_i,
  output logic [TT_W-1:0]  tt_o,
  output logic             tt_valid_o,
  input  logic             tt_ready_i
`ifdef SUBCKT_TOGGLE_COUNT_EN
  ,
  output logic [3:0]       toggle_cnt_o
`endif
);
  state_t state, state_nx;
  logic accept, settle_done;
  assign accept = state == IDLE && start_i;
  subckt_settle_timer #(.CYCLES(SETTLE_CYCLES)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept || state == SAMPLE),
    .en   (state == DRIVE),
    .done (settle_done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   state_nx = start_i ? DRIVE : IDLE;
      DRIVE:  state_nx = settle_done ? SAMPLE : DRIVE;
      SAMPLE: state_nx = vec_o == '1 ? DONE : DRIVE;
      DONE:   state_nx = tt_ready_i ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vec_o <= '0;
      tt_o  <= '0;
    end else if (accept) begin
      vec_o <= '0;
      tt_o  <= '0;
    end else if (state == SAMPLE) begin
      vec_o        <= vec_o + VEC_W'(1);
      tt_o[vec_o]  <= dut_out_i;
    end
`ifdef SUBCKT_TOGGLE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) toggle_cnt_o <= '0;
    else if (accept) toggle_cnt_o <= '0;
    else if (state == SAMPLE && vec_o != '0 && dut_out_i != tt_o[vec_o - VEC_W'(1)])
      toggle_cnt_o <= toggle_cnt_o + 4'd1;
`endif
  assign busy_o = state == DRIVE || state == SAMPLE;
  assign tt_valid_o = state == DONE;
endmodule
